// File: rtl/hash_sched_pkg.sv
// Shared types and defaults for the hash round sequencer.
package hash_sched_pkg;

    localparam int ROUNDS_DEF     = 64;
    localparam int CNT_W_DEF      = 6;
    localparam int NONCE_W_DEF    = 32;
    localparam int PIPE_DEPTH_DEF = 2;
    localparam int CNT_IDLE_DEF   = ROUNDS_DEF - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        CHECK,
        DONE
    } state_e;

    // The counter parks on the last round index whenever it is not running.
    function automatic int cnt_idle(input int rounds);
        return rounds - 1;
    endfunction

endpackage

// File: rtl/round_delay.sv
// Resettable shift chain that aligns the round counter with the datapath latency.
module round_delay #(
    parameter int              CNT_W      = 6,
    parameter int              PIPE_DEPTH = 2,
    parameter logic [CNT_W-1:0] IDLE_VAL  = '1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             en,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] dout
);

    logic [PIPE_DEPTH-1:0][CNT_W-1:0] stage;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            stage <= {PIPE_DEPTH{IDLE_VAL}};
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < PIPE_DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[PIPE_DEPTH-1];

endmodule

// File: rtl/hash_round_sched.sv
// Round sequencer and nonce sweeper for the hash compression datapath.
// Optional RUN/DRAIN stall input enabled by defining HASH_ROUND_SCHED_STALL_EN.
module hash_round_sched
    import hash_sched_pkg::*;
#(
    parameter int ROUNDS     = ROUNDS_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int NONCE_W    = NONCE_W_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               start,
    input  logic               abort,
`ifdef HASH_ROUND_SCHED_STALL_EN
    input  logic               stall,
`endif
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic               hit,
    output logic               busy,
    output logic               load,
    output logic [CNT_W-1:0]   counter,
    output logic [CNT_W-1:0]   counter_2d,
    output logic [NONCE_W-1:0] nonce,
    output logic               done,
    output logic               found
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(cnt_idle(ROUNDS));
    localparam int               DRN_W    = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_DEPTH - 1);

    state_e             state, state_nx;
    logic [CNT_W-1:0]   cnt_q;
    logic [DRN_W-1:0]   drn_q;
    logic [NONCE_W-1:0] nonce_q, last_q;
    logic               found_q;
    logic               frz;

    // Abort wins over stall so a frozen sweep can still be cancelled.
`ifdef HASH_ROUND_SCHED_STALL_EN
    assign frz = stall && !abort && (state == RUN || state == DRAIN);
`else
    assign frz = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else if (!frz) begin
            case (state)
                IDLE:    if (start) state_nx = LOAD;
                LOAD:    state_nx = RUN;
                RUN:     if (cnt_q == CNT_LAST) state_nx = DRAIN;
                DRAIN:   if (drn_q == DRN_LAST) state_nx = CHECK;
                CHECK:   state_nx = (hit || nonce_q == last_q) ? DONE : LOAD;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q   <= CNT_LAST;
            drn_q   <= '0;
            nonce_q <= '0;
            last_q  <= '0;
            found_q <= 1'b0;
        end else if (abort) begin
            cnt_q <= CNT_LAST;
            drn_q <= '0;
            if (state != IDLE) found_q <= 1'b0;
        end else if (!frz) begin
            if (state == LOAD)
                cnt_q <= '0;
            else if (state == RUN && cnt_q != CNT_LAST)
                cnt_q <= cnt_q + CNT_W'(1);
            else
                cnt_q <= CNT_LAST;

            drn_q <= (state == DRAIN) ? drn_q + DRN_W'(1) : '0;

            if (state == IDLE && start) begin
                nonce_q <= nonce_start;
                last_q  <= nonce_end;
                found_q <= 1'b0;
            end else if (state == CHECK) begin
                if (hit)                   found_q <= 1'b1;
                else if (nonce_q != last_q) nonce_q <= nonce_q + NONCE_W'(1);
            end
        end
    end

    round_delay #(
        .CNT_W      (CNT_W),
        .PIPE_DEPTH (PIPE_DEPTH),
        .IDLE_VAL   (CNT_LAST)
    ) u_delay (
        .clk     (clk),
        .reset_L (reset_L),
        .en      (!frz),
        .din     (cnt_q),
        .dout    (counter_2d)
    );

    assign busy    = (state != IDLE);
    assign load    = (state == LOAD);
    assign done    = (state == DONE);
    assign counter = cnt_q;
    assign nonce   = nonce_q;
    assign found   = found_q;

endmodule

// File: tb/tb_hash_round_sched.sv
// Randomised and directed checks of hash_round_sched against a per-nonce schedule model.
module tb_hash_round_sched;

    localparam int ROUNDS = 64;
    localparam int PD     = 2;
    localparam int K_LOAD = 0, K_RUN = 1, K_DRAIN = 2, K_CHECK = 3, K_DONE = 4;

    typedef struct {
        int kind;
        int idx;
    } ent_t;

    logic        clk = 0, reset_L = 1, start = 0, abort = 0, hit = 0, stall = 0;
    logic [31:0] nonce_start = 0, nonce_end = 0;
    logic        busy, load, done, found;
    logic [5:0]  counter, counter_2d;
    logic [31:0] nonce;

    int n_checks = 0, n_fail = 0, cyc = 0;

    always #5 clk = ~clk;

    hash_round_sched dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .start       (start),
        .abort       (abort),
`ifdef HASH_ROUND_SCHED_STALL_EN
        .stall       (stall),
`endif
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .hit         (hit),
        .busy        (busy),
        .load        (load),
        .counter     (counter),
        .counter_2d  (counter_2d),
        .nonce       (nonce),
        .done        (done),
        .found       (found)
    );

    // Model: each tested nonce is a fixed list of cycles (load, rounds, drain, check).
    ent_t        q[$];
    ent_t        cur;
    bit          m_idle = 1, m_found = 0;
    logic [31:0] m_nonce = 0, m_last = 0;
    int          p0 = ROUNDS - 1, p1 = ROUNDS - 1;

    function automatic int exp_cnt();
        return (m_idle || cur.kind != K_RUN) ? ROUNDS - 1 : cur.idx;
    endfunction

    task automatic push_ent(input int k, input int i);
        ent_t e;
        e.kind = k;
        e.idx  = i;
        q.push_back(e);
    endtask

    task automatic push_nonce();
        push_ent(K_LOAD, 0);
        for (int i = 0; i < ROUNDS; i++) push_ent(K_RUN, i);
        for (int i = 0; i < PD; i++) push_ent(K_DRAIN, i);
        push_ent(K_CHECK, 0);
    endtask

    initial forever begin
        @(posedge clk or negedge reset_L);
        if (!reset_L) begin
            q.delete();
            m_idle = 1; m_found = 0; m_nonce = 0; m_last = 0;
            p0 = ROUNDS - 1; p1 = ROUNDS - 1;
        end else if (clk) begin
            int c;
            bit frz;
            c   = exp_cnt();
            frz = 0;
            cyc++;
            if (abort) begin
                if (!m_idle) begin
                    q.delete();
                    m_idle  = 1;
                    m_found = 0;
                end
            end else if (m_idle) begin
                if (start) begin
                    m_nonce = nonce_start;
                    m_last  = nonce_end;
                    m_found = 0;
                    push_nonce();
                    cur    = q.pop_front();
                    m_idle = 0;
                end
            end else if (stall && (cur.kind == K_RUN || cur.kind == K_DRAIN)) begin
                frz = 1;
            end else begin
                if (cur.kind == K_CHECK) begin
                    if (hit) begin
                        m_found = 1;
                        push_ent(K_DONE, 0);
                    end else if (m_nonce == m_last) begin
                        push_ent(K_DONE, 0);
                    end else begin
                        m_nonce = m_nonce + 1;
                        push_nonce();
                    end
                end
                if (q.size() > 0) cur = q.pop_front();
                else              m_idle = 1;
            end
            if (!frz) begin
                p1 = p0;
                p0 = c;
            end
        end
    end

    // Per-cycle compare plus event capture for the directed tests.
    bit          done_seen = 0;
    int          done_cyc = 0, load_cnt = 0, mark_a = -1, mark_b = -1;
    logic [5:0]  cnt_a = 0, cnt_b = 0;
    logic [31:0] load_nonces[$];

    initial forever begin
        @(negedge clk);
        if (reset_L) begin
            logic e_busy, e_load, e_done;
            int   ec;
            e_busy = !m_idle;
            e_load = !m_idle && cur.kind == K_LOAD;
            e_done = !m_idle && cur.kind == K_DONE;
            ec     = exp_cnt();
            n_checks++;
            if (busy !== e_busy || load !== e_load || done !== e_done ||
                counter !== 6'(ec) || counter_2d !== 6'(p1) ||
                nonce !== m_nonce || found !== m_found) begin
                n_fail++;
                $display("FAIL cycle_check cyc=%0d got busy=%b load=%b done=%b cnt=%0d c2d=%0d nonce=%h found=%b; want busy=%b load=%b done=%b cnt=%0d c2d=%0d nonce=%h found=%b",
                         cyc, busy, load, done, counter, counter_2d, nonce, found,
                         e_busy, e_load, e_done, ec, p1, m_nonce, m_found);
            end
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            if (load) begin
                load_cnt++;
                load_nonces.push_back(nonce);
            end
            if (cyc == mark_a) cnt_a = counter;
            if (cyc == mark_b) cnt_b = counter;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    int hit_mode = 0;          // 0: never hit in CHECK, 1: hit on target, 2: random
    logic [31:0] hit_target = 0;
    int T = 0;

    task automatic step();
        @(posedge clk);
        #2;
        if (!m_idle && cur.kind == K_CHECK)
            hit = (hit_mode == 2) ? 1'($urandom % 2) : (hit_mode == 1 && m_nonce == hit_target);
        else
            hit = 1'($urandom % 2);
    endtask

    task automatic arm_monitors();
        T         = cyc;
        done_seen = 0;
        load_cnt  = 0;
        load_nonces.delete();
        mark_a    = T + 2;
        mark_b    = T + 65;
    endtask

    task automatic start_sweep(input logic [31:0] s, input logic [31:0] e);
        step();
        nonce_start = s;
        nonce_end   = e;
        start       = 1;
        arm_monitors();
        step();
        start = 0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !done_seen; i++) step();
        chk("done_timeout", 32'(done_seen), 1);
    endtask

    task automatic wait_run_idx(input int idx);
        int n;
        n = 0;
        while (!(!m_idle && cur.kind == K_RUN && cur.idx == idx) && n < 200) begin
            step();
            n++;
        end
        chk("reach_run_idx", 32'(n < 200), 1);
    endtask

    logic [31:0] wrap_exp[4];

    initial begin
        wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFF;
        wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0001;

        // Power-on reset values
        #1 reset_L = 0;
        #1;
        chk("rst_counter", 32'(counter), 63);
        chk("rst_counter_2d", 32'(counter_2d), 63);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_nonce", nonce, 0);
        chk("rst_flags", {29'd0, load, done, found}, 0);
        step(); step();
        reset_L = 1;
        step();

        // Single nonce, no hit
        hit_mode = 0;
        start_sweep(32'h10, 32'h10);
        wait_done(200);
        chk("single_latency", 32'(done_cyc - T), 69);
        chk("single_loads", 32'(load_cnt), 1);
        chk("single_cnt_first", 32'(cnt_a), 0);
        chk("single_cnt_last", 32'(cnt_b), 63);
        chk("single_found", 32'(found), 0);
        chk("single_nonce", nonce, 32'h10);

        // Hit on the fourth nonce of a long range
        hit_mode = 1; hit_target = 32'h103;
        start_sweep(32'h100, 32'h1FF);
        wait_done(400);
        chk("hit_latency", 32'(done_cyc - T), 4 * 68 + 1);
        chk("hit_loads", 32'(load_cnt), 4);
        chk("hit_found", 32'(found), 1);
        chk("hit_nonce", nonce, 32'h103);

        // Wrap through 2^32-1
        hit_mode = 0;
        start_sweep(32'hFFFF_FFFE, 32'h0000_0001);
        wait_done(400);
        chk("wrap_loads", 32'(load_cnt), 4);
        for (int i = 0; i < 4 && i < load_nonces.size(); i++)
            chk("wrap_nonce_seq", load_nonces[i], wrap_exp[i]);
        chk("wrap_found", 32'(found), 0);
        chk("wrap_latency", 32'(done_cyc - T), 4 * 68 + 1);

        // Abort at counter 30, then immediate restart
        start_sweep(32'h20, 32'h30);
        wait_run_idx(30);
        abort = 1;
        step();
        abort = 0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_counter", 32'(counter), 63);
        chk("abort_no_done", 32'(done_seen), 0);
        nonce_start = 32'h55;
        nonce_end   = 32'h55;
        start       = 1;
        arm_monitors();
        step();
        start = 0;
        wait_done(200);
        chk("restart_nonce", nonce, 32'h55);
        chk("restart_latency", 32'(done_cyc - T), 69);

        // start together with abort in IDLE is refused
        step();
        start = 1; abort = 1;
        step();
        start = 0; abort = 0;
        chk("start_abort_idle", 32'(busy), 0);

`ifdef HASH_ROUND_SCHED_STALL_EN
        // Five stalled cycles at counter 10 delay done by five
        start_sweep(32'h40, 32'h40);
        wait_run_idx(10);
        stall = 1;
        repeat (5) step();
        stall = 0;
        wait_done(200);
        chk("stall_latency", 32'(done_cyc - T), 74);
`endif

        // Asynchronous reset mid-RUN
        start_sweep(32'h77, 32'h80);
        wait_run_idx(20);
        #1 reset_L = 0;
        #1;
        chk("async_counter", 32'(counter), 63);
        chk("async_counter_2d", 32'(counter_2d), 63);
        chk("async_busy", 32'(busy), 0);
        chk("async_nonce", nonce, 0);
        step(); step();
        reset_L = 1;
        step();

        // Randomised traffic: short ranges, wrap edges, stray starts/hits, rare aborts
        hit_mode = 2;
        for (int i = 0; i < 5000; i++) begin
            step();
            start       = ($urandom % 6) == 0;
            abort       = ($urandom % 400) == 0;
            nonce_start = ($urandom % 2) ? $urandom : 32'hFFFF_FFFF - ($urandom % 3);
            nonce_end   = nonce_start + ($urandom % 3);
`ifdef HASH_ROUND_SCHED_STALL_EN
            stall       = ($urandom % 8) == 0;
`endif
        end
        start = 0; abort = 0; stall = 0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hash_round_sched.md
Name: hash_round_sched

Overview:
- Round sequencer and nonce sweeper for the hash compression datapath.
- Generates the round counter and its pipeline-aligned delayed copy that the message-schedule and compression stages consume.
- Steps the nonce across a programmed range, one full compression per nonce.
- Reports the first nonce whose result the downstream comparator flags as a hit.

Parameters:
- ROUNDS, 64: rounds per compression; counter runs 0..ROUNDS-1.
- CNT_W, 6: counter width; must satisfy 2^CNT_W >= ROUNDS.
- NONCE_W, 32: nonce width.
- PIPE_DEPTH, 2: datapath latency in cycles between counter and counter_2d.

Ports:
- clk  in  1  clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  cancel the sweep; takes priority over all other inputs.
- nonce_start  in  NONCE_W  first nonce; latched on an accepted start.
- nonce_end  in  NONCE_W  last nonce, inclusive; latched on an accepted start.
- hit  in  1  comparator result for the current nonce; sampled only in CHECK.
- busy  out  1  high in every state except IDLE.
- load  out  1  one-cycle pulse telling the datapath to load IV and the block for the current nonce.
- counter  out  CNT_W  current round index.
- counter_2d  out  CNT_W  counter delayed PIPE_DEPTH cycles.
- nonce  out  NONCE_W  nonce under test; holds the result after done.
- done  out  1  one-cycle completion pulse.
- found  out  1  valid from done until the next accepted start; 1 means nonce is the winning value.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - State = IDLE.
  - counter and all delay stages = ROUNDS-1 (63).
  - nonce = 0, busy = 0, load = 0, done = 0, found = 0.
- Delay chain: each stage registers the previous one every cycle, in every state. counter_2d equals counter from PIPE_DEPTH cycles earlier.
- counter holds ROUNDS-1 in every state except RUN.
- IDLE:
  - start=1 and abort=0 → latch nonce_start into nonce and nonce_end into the internal last register, clear found, go to LOAD.
- LOAD:
  - load=1 for this one cycle; counter = ROUNDS-1.
  - Go to RUN.
- RUN:
  - counter = 0 on the first RUN cycle, then +1 per cycle.
  - After the cycle with counter = ROUNDS-1, go to DRAIN.
- DRAIN:
  - Lasts PIPE_DEPTH cycles, timed by an internal drain counter.
  - Ends with counter_2d = ROUNDS-1; go to CHECK.
- CHECK (one cycle), sample hit:
  - hit=1 → found set, nonce held, go to DONE.
  - hit=0 and nonce == last → found = 0, go to DONE.
  - Otherwise → nonce = nonce+1 modulo 2^NONCE_W, go to LOAD.
- DONE:
  - done=1 for one cycle, then IDLE.
- Cycle cost is 1+ROUNDS+PIPE_DEPTH+1 = 68 cycles per nonce.
  - Single-nonce sweep: start accepted at cycle T → done=1 at T+69.
- Wrap-around: nonce_end < nonce_start sweeps through 2^NONCE_W-1 and 0 up to nonce_end. nonce_end == nonce_start means exactly one nonce.
- Precedence and corner cases:
  - abort=1 in any non-IDLE state → IDLE next cycle; done not pulsed; found = 0; counter returns to ROUNDS-1.
  - start while busy is ignored.
  - start and abort together in IDLE → stay IDLE.
  - reset_L low mid-sweep → immediate reset values, no done pulse.
  - hit outside CHECK is ignored.

Optional Feature:
- Macro: HASH_ROUND_SCHED_STALL_EN.
- With the macro defined:
  - Extra input port stall (1 bit).
  - stall=1 in RUN or DRAIN freezes the FSM, counter, drain counter and every delay stage.
  - abort and reset still override stall.
  - Each stalled cycle adds one cycle to the per-nonce cost.
- Without the macro: no stall port; timing exactly as in Behaviour.

Decomposition:
- Package hash_sched_pkg:
  - State enum: IDLE, LOAD, RUN, DRAIN, CHECK, DONE.
  - Default constants for ROUNDS, CNT_W and PIPE_DEPTH.
  - Counter idle value, ROUNDS-1.
- Sub-module round_delay (parameters CNT_W, PIPE_DEPTH, IDLE_VAL):
  - Resettable shift chain producing counter_2d.
  - Accepts an enable input so the stall feature can freeze it.

Test Plan:
- Reset: reset_L=0 mid-RUN, async → counter = counter_2d = 63, busy = 0, nonce = 0 immediately, with no clock edge needed.
- Single nonce: nonce_start = nonce_end = 0x10, hit=0 → one load pulse; counter steps 0..63 on cycles T+2..T+65; done at T+69; found = 0; nonce = 0x10.
- Hit mid-sweep: range 0x100..0x1FF, hit=1 only in CHECK for nonce 0x103 → four load pulses; done at T+4*68+1; found = 1; nonce = 0x103.
- Wrap: nonce_start = 0xFFFFFFFE, nonce_end = 0x00000001, hit never → nonces FFFFFFFE, FFFFFFFF, 0, 1 tested; done with found = 0.
- Abort at RUN counter = 30 → IDLE next cycle; no done pulse; a start in the following cycle is accepted and restarts from the new nonce_start.
- With HASH_ROUND_SCHED_STALL_EN, stall for 5 cycles at counter = 10 → counter and counter_2d frozen; done arrives 5 cycles later than without stall.
